// File: rtl/ro_bank_scheduler_if.sv
// Control/result bus for ro_bank_scheduler.
// master: drives start/stop/pattern/dwell, receives busy/results/done.
// slave : the scheduler side of the same signals.
interface ro_bank_scheduler_if #(
    parameter int unsigned NUM_RO = 8,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic              stop;
    logic [NUM_RO-1:0] pattern;
    logic [WIN_W-1:0]  dwell;
    logic              busy;
    logic              meas_valid;
    logic [4:0]        meas_idx;
    logic [CNT_W-1:0]  meas_count;
    logic              done;
    logic              aborted;

    modport master (
        output start, stop, pattern, dwell,
        input  busy, meas_valid, meas_idx, meas_count, done, aborted
    );

    modport slave (
        input  start, stop, pattern, dwell,
        output busy, meas_valid, meas_idx, meas_count, done, aborted
    );
endinterface

// File: rtl/ro_bank_scheduler.sv
// Ring-oscillator bank scheduler: staggered enable of a latched pattern,
// per-oscillator edge counting over a dwell window, ascending result stream,
// then staggered disable in descending order.
// Ports: clk, rst_n (async active-low); bus (slave modport: start/stop/
// pattern/dwell in, busy/meas_*/done/aborted out); ro_in raw oscillator
// outputs (async to clk); ro_en registered per-oscillator enables.
module ro_bank_scheduler #(
    parameter int unsigned NUM_RO      = 8,
    parameter int unsigned STAGGER_CYC = 16,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ro_bank_scheduler_if.slave    bus,
    input  logic [NUM_RO-1:0]     ro_in,
    output logic [NUM_RO-1:0]     ro_en
);
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned STEP_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STAGGER_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RAMP_UP, S_MEAS, S_REPORT, S_RAMP_DN, S_FINISH
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic [NUM_RO-1:0]             r_pattern, w_pattern_nxt;
    logic [WIN_W-1:0]              r_dwell, w_dwell_nxt;
    logic                          r_abort, w_abort_nxt;
    logic [NUM_RO-1:0]             r_pend, w_pend_nxt;
    logic [STEP_W-1:0]             r_step, w_step_nxt;
    logic [WIN_W-1:0]              r_win, w_win_nxt;
    logic [NUM_RO-1:0][CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [NUM_RO-1:0]             r_ro_en, w_ro_en_nxt;
    logic                          r_busy, w_busy_nxt;
    logic                          r_meas_valid, w_meas_valid_nxt;
    logic [IDX_W-1:0]              r_meas_idx, w_meas_idx_nxt;
    logic [CNT_W-1:0]              r_meas_count, w_meas_count_nxt;
    logic                          r_done, w_done_nxt;
    logic                          r_aborted, w_aborted_nxt;
    logic [NUM_RO-1:0]             r_sync1, r_sync2, r_hist;

    logic [NUM_RO-1:0]             w_edge;
    logic [IDX_W-1:0]              w_pat_lo, w_pend_lo, w_en_hi;
    logic [NUM_RO-1:0]             w_pat_lo_bit, w_pend_lo_bit, w_ro_en_dn;
    logic [CNT_W-1:0]              w_cnt_sel;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_RO-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_RO) - 1; i >= 0; i--)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] highest_idx(input logic [NUM_RO-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NUM_RO); i++)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    // Two-flop synchronizer plus history flop; edge = new high after low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge        = r_sync2 & ~r_hist;
    assign w_pat_lo      = lowest_idx(bus.pattern);
    assign w_pend_lo     = lowest_idx(r_pend);
    assign w_en_hi       = highest_idx(r_ro_en);
    assign w_pat_lo_bit  = NUM_RO'(1) << w_pat_lo;
    assign w_pend_lo_bit = NUM_RO'(1) << w_pend_lo;
    // Ramp-down removes the highest currently enabled oscillator.
    assign w_ro_en_dn    = r_ro_en & ~(NUM_RO'(1) << w_en_hi);

    // Count of the oscillator being reported this cycle.
    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < int'(NUM_RO); i++)
            if (IDX_W'(i) == w_pend_lo) w_cnt_sel = r_cnt[i];
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_pattern_nxt    = r_pattern;
        w_dwell_nxt      = r_dwell;
        w_abort_nxt      = r_abort;
        w_pend_nxt       = r_pend;
        w_step_nxt       = r_step;
        w_win_nxt        = r_win;
        w_cnt_nxt        = r_cnt;
        w_ro_en_nxt      = r_ro_en;
        w_busy_nxt       = r_busy;
        w_meas_valid_nxt = 1'b0;
        w_meas_idx_nxt   = r_meas_idx;
        w_meas_count_nxt = r_meas_count;
        w_done_nxt       = 1'b0;
        w_aborted_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pattern_nxt = bus.pattern;
                    w_dwell_nxt   = bus.dwell;
                    w_abort_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
                    if (bus.pattern != '0) begin
                        w_ro_en_nxt = w_pat_lo_bit;
                        w_pend_nxt  = bus.pattern & ~w_pat_lo_bit;
                        w_step_nxt  = STEP_RELOAD;
                        w_state_nxt = S_RAMP_UP;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_RAMP_UP: begin
                if (bus.stop) begin
                    w_abort_nxt = 1'b1;
                    w_ro_en_nxt = w_ro_en_dn;
                    w_step_nxt  = STEP_RELOAD;
                    w_state_nxt = S_RAMP_DN;
                end else if (r_step != '0) begin
                    w_step_nxt = r_step - STEP_W'(1);
                end else if (r_pend != '0) begin
                    w_ro_en_nxt = r_ro_en | w_pend_lo_bit;
                    w_pend_nxt  = r_pend & ~w_pend_lo_bit;
                    w_step_nxt  = STEP_RELOAD;
                end else begin
                    // dwell of 0 behaves as a 1-cycle window
                    w_cnt_nxt   = '0;
                    w_win_nxt   = (r_dwell == '0) ? '0 : r_dwell - WIN_W'(1);
                    w_state_nxt = S_MEAS;
                end
            end
            S_MEAS: begin
                if (bus.stop) begin
                    w_abort_nxt = 1'b1;
                    w_ro_en_nxt = w_ro_en_dn;
                    w_step_nxt  = STEP_RELOAD;
                    w_state_nxt = S_RAMP_DN;
                end else begin
                    for (int i = 0; i < int'(NUM_RO); i++)
                        if (r_pattern[i] && w_edge[i] && (r_cnt[i] != '1))
                            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    if (r_win == '0) begin
                        w_pend_nxt  = r_pattern;
                        w_state_nxt = S_REPORT;
                    end else begin
                        w_win_nxt = r_win - WIN_W'(1);
                    end
                end
            end
            S_REPORT: begin
                w_meas_valid_nxt = 1'b1;
                w_meas_idx_nxt   = w_pend_lo;
                w_meas_count_nxt = w_cnt_sel;
                w_pend_nxt       = r_pend & ~w_pend_lo_bit;
                if ((r_pend & ~w_pend_lo_bit) == '0) begin
                    w_ro_en_nxt = w_ro_en_dn;
                    w_step_nxt  = STEP_RELOAD;
                    w_state_nxt = S_RAMP_DN;
                end
            end
            S_RAMP_DN: begin
                if (r_step != '0) begin
                    w_step_nxt = r_step - STEP_W'(1);
                end else if (r_ro_en != '0) begin
                    w_ro_en_nxt = w_ro_en_dn;
                    w_step_nxt  = STEP_RELOAD;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done_nxt    = 1'b1;
                w_aborted_nxt = r_abort;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_dwell      <= '0;
            r_abort      <= 1'b0;
            r_pend       <= '0;
            r_step       <= '0;
            r_win        <= '0;
            r_cnt        <= '0;
            r_ro_en      <= '0;
            r_busy       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_meas_idx   <= '0;
            r_meas_count <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pattern    <= w_pattern_nxt;
            r_dwell      <= w_dwell_nxt;
            r_abort      <= w_abort_nxt;
            r_pend       <= w_pend_nxt;
            r_step       <= w_step_nxt;
            r_win        <= w_win_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ro_en      <= w_ro_en_nxt;
            r_busy       <= w_busy_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_meas_idx   <= w_meas_idx_nxt;
            r_meas_count <= w_meas_count_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    assign ro_en          = r_ro_en;
    assign bus.busy       = r_busy;
    assign bus.meas_valid = r_meas_valid;
    assign bus.meas_idx   = r_meas_idx;
    assign bus.meas_count = r_meas_count;
    assign bus.done       = r_done;
    assign bus.aborted    = r_aborted;
endmodule

// File: tb/tb_ro_bank_scheduler.sv
// Scoreboard bench for ro_bank_scheduler (NUM_RO=4, STAGGER_CYC=4, CNT_W=4).
module tb_ro_bank_scheduler;
    logic       clk;
    logic       rst_n;
    logic [3:0] ro_in;
    logic [3:0] ro_en;
    int         ro_mode;

    ro_bank_scheduler_if #(.NUM_RO(4), .WIN_W(16), .CNT_W(4)) bus ();

    ro_bank_scheduler #(.NUM_RO(4), .STAGGER_CYC(4), .WIN_W(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .ro_in (ro_in),
        .ro_en (ro_en)
    );

    typedef struct {
        bit is_done;
        int idx;
        int lo;
        int hi;
        bit abrt;
        int gap;
    } exp_t;

    typedef struct {
        logic [3:0] val;
        int         gap;
    } en_t;

    exp_t exp_q[$];
    en_t  ro_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator model, phase-offset from clk: mode 1 = bit0 at clk/10, mode 2 = all at clk/4.
    initial begin
        int ph;
        ph    = 0;
        ro_in = '0;
        #3;
        forever begin
            #10;
            ph++;
            case (ro_mode)
                1:       ro_in = {3'b000, ((ph % 10) < 5)};
                2:       ro_in = ((ph % 4) < 2) ? 4'hF : 4'h0;
                default: ro_in = '0;
            endcase
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input longint act);
        checks++;
        failures++;
        $display("FAIL %s: got %0d want no event", name, act);
    endtask

    task automatic push_en(input logic [3:0] v, input int gap);
        en_t e;
        e.val = v;
        e.gap = gap;
        ro_q.push_back(e);
    endtask

    task automatic push_res(input int idx, input int lo, input int hi, input int gap);
        exp_t e;
        e = '{is_done: 1'b0, idx: idx, lo: lo, hi: hi, abrt: 1'b0, gap: gap};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input bit abrt, input int gap);
        exp_t e;
        e = '{is_done: 1'b1, idx: 0, lo: 0, hi: 0, abrt: abrt, gap: gap};
        exp_q.push_back(e);
    endtask

    // Monitor: pops expectations on every ro_en change, result and done.
    logic [3:0] prev_en;
    logic       prev_busy;
    int         ref_cyc, last_en_cyc, last_mv_cyc;
    always @(negedge clk) begin
        exp_t e;
        en_t  n;
        if (!rst_n) begin
            prev_en   = ro_en;
            prev_busy = bus.busy;
        end else begin
            if (bus.busy && !prev_busy) begin
                ref_cyc     = cyc;
                last_en_cyc = cyc;
            end
            if (ro_en !== prev_en) begin
                if (ro_q.size() == 0) fail_event("ro_en_unexpected", ro_en);
                else begin
                    n = ro_q.pop_front();
                    check("ro_en_value", ro_en, n.val);
                    if (n.gap >= 0) check("ro_en_gap", cyc - last_en_cyc, n.gap);
                end
                last_en_cyc = cyc;
            end
            if (bus.meas_valid) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) fail_event("meas_valid_unexpected", bus.meas_idx);
                else begin
                    e = exp_q.pop_front();
                    check("res_idx", bus.meas_idx, e.idx);
                    checks++;
                    if (bus.meas_count < e.lo || bus.meas_count > e.hi) begin
                        failures++;
                        $display("FAIL res_count idx%0d: got %0d want %0d..%0d",
                                 e.idx, bus.meas_count, e.lo, e.hi);
                    end
                    if (e.gap >= 0) check("res_gap", cyc - last_mv_cyc, e.gap);
                end
                last_mv_cyc = cyc;
            end
            if (bus.done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) fail_event("done_unexpected", cyc - ref_cyc);
                else begin
                    e = exp_q.pop_front();
                    check("done_aborted", bus.aborted, e.abrt);
                    check("done_busy_low", bus.busy, 0);
                    if (e.gap >= 0) check("done_latency", cyc - ref_cyc, e.gap);
                end
                done_cnt++;
            end
            prev_en   = ro_en;
            prev_busy = bus.busy;
        end
    end

    // Pulse start for one cycle; pattern/dwell are scrambled right after acceptance.
    task automatic run_start(input logic [3:0] pat, input int dw, input bit stp);
        @(negedge clk);
        bus.pattern = pat;
        bus.dwell   = 16'(dw);
        bus.start   = 1'b1;
        bus.stop    = stp;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pattern = ~pat;
        bus.dwell   = 16'(dw + 7);
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        bit got;
        d0  = done_cnt;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(posedge clk);
            if (done_cnt != d0) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1);
        check({name, "_exp_drained"}, exp_q.size(), 0);
        check({name, "_ro_drained"}, ro_q.size(), 0);
        exp_q.delete();
        ro_q.delete();
    endtask

    initial begin
        ro_mode     = 0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pattern = '0;
        bus.dwell   = '0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        #20;
        check("reset_outputs", {ro_en, bus.busy, bus.meas_valid, bus.done, bus.aborted,
                                bus.meas_idx, bus.meas_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main run: 1011, dwell 100, bit0 at 10 edges/100 cycles; start re-pulsed in MEAS.
        ro_mode = 1;
        push_en(4'b0001, 0);
        push_en(4'b0011, 4);
        push_en(4'b1011, 4);
        push_en(4'b0011, 107);
        push_en(4'b0001, 4);
        push_en(4'b0000, 4);
        push_res(0, 9, 11, -1);
        push_res(1, 0, 0, 1);
        push_res(3, 0, 0, 1);
        push_done(1'b0, 128);
        run_start(4'b1011, 100, 1'b0);
        repeat (30) @(negedge clk);
        bus.pattern = 4'b1111;
        bus.dwell   = 16'd5;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done(300, "main");
        ro_mode = 0;
        repeat (20) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_ro_en", ro_en, 0);

        // Empty pattern with simultaneous stop: straight to done, not aborted.
        push_done(1'b0, 1);
        run_start(4'b0000, 50, 1'b1);
        wait_done(20, "empty");

        // Stop two cycles into MEAS: no results, ordered abort ramp-down.
        push_en(4'b0010, 0);
        push_en(4'b0110, 4);
        push_en(4'b0010, 6);
        push_en(4'b0000, 4);
        push_done(1'b1, 19);
        run_start(4'b0110, 100, 1'b0);
        repeat (9) @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_done(100, "stop");

        // Saturation: 50 edges into a 4-bit counter.
        ro_mode = 2;
        push_en(4'b0001, 0);
        push_en(4'b0101, 4);
        push_en(4'b0001, 206);
        push_en(4'b0000, 4);
        push_res(0, 15, 15, -1);
        push_res(2, 15, 15, 1);
        push_done(1'b0, 219);
        run_start(4'b0101, 200, 1'b0);
        wait_done(400, "sat");
        ro_mode = 0;

        // Async reset mid ramp-up with ro_en=0011, then a fresh run.
        push_en(4'b0001, 0);
        push_en(4'b0011, 4);
        run_start(4'b0011, 10, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ro_en", ro_en, 0);
        check("rst_async_busy", bus.busy, 0);
        check("rst_ramp_seen", ro_q.size(), 0);
        exp_q.delete();
        ro_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        push_en(4'b0001, 0);
        push_en(4'b0000, 10);
        push_res(0, 0, 0, -1);
        push_done(1'b0, 15);
        run_start(4'b0001, 5, 1'b0);
        wait_done(100, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
